vend_ctrl_multi: RTL and testbench

Parametrised multi-product vending controller, successor to the single-price coin FSM. It accumulates coin credit and vends one of `N_PROD` products with individually parametrised prices. It returns change or refunds as a stream of individual coins over a valid/ready handshake. It sits between the coin acceptor (2-bit coin code) and the dispenser/change-hopper drivers.

---
 rtl/vend_ctrl_multi.sv | 170 +++++++++++++++++
 tb/tb_vend_ctrl_multi.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_ctrl_multi.sv
// vend_ctrl_multi: multi-product coin vending controller.
// Accumulates coin credit, vends one of N_PROD products at individually
// parametrised prices, and pays change or refunds as a stream of single coins
// over a chg_valid/chg_ready handshake.
// Optional build macro: VEND_CREDIT_HOLD_EN -- when defined, leftover credit
// after a vend stays in the machine for further purchases instead of being
// returned automatically; it is only paid out through cancel.
module vend_ctrl_multi #(
  parameter int N_PROD     = 4,
  parameter int CREDIT_W   = 8,
  parameter int MAX_CREDIT = 100,
  parameter logic [N_PROD*CREDIT_W-1:0] PRICES = {8'd100, 8'd60, 8'd45, 8'd30}
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                coin,
  input  logic                      sel,
  input  logic [$clog2(N_PROD)-1:0] sel_id,
  input  logic                      cancel,
  input  logic                      chg_ready,
  output logic                      vend,
  output logic [$clog2(N_PROD)-1:0] vend_id,
  output logic                      chg_valid,
  output logic [1:0]                chg_coin,
  output logic [CREDIT_W-1:0]       credit,
  output logic                      coin_rej,
  output logic                      sel_nack,
  output logic                      busy
);

  localparam int ID_W = $clog2(N_PROD);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_VEND   = 2'd1,
    S_CHANGE = 2'd2,
    S_REFUND = 2'd3
  } state_t;

  state_t state;

  // Value in credit units of a 2-bit coin code (00 means no coin).
  function automatic logic [CREDIT_W-1:0] coin_val(input logic [1:0] c);
    logic [CREDIT_W-1:0] v;
    v = '0;
    case (c)
      2'b01:   v = CREDIT_W'(5);
      2'b10:   v = CREDIT_W'(10);
      2'b11:   v = CREDIT_W'(25);
      default: v = '0;
    endcase
    return v;
  endfunction

  // Largest coin that does not exceed the amount still owed.
  function automatic logic [1:0] greedy_coin(input logic [CREDIT_W-1:0] amt);
    logic [1:0] c;
    if (amt >= CREDIT_W'(25))      c = 2'b11;
    else if (amt >= CREDIT_W'(10)) c = 2'b10;
    else                           c = 2'b01;
    return c;
  endfunction

  // Price lookup by product index; out-of-range indices return zero and are
  // rejected separately, so the slice is never taken out of bounds.
  function automatic logic [CREDIT_W-1:0] price_of(input logic [ID_W-1:0] id);
    logic [CREDIT_W-1:0] p;
    p = '0;
    for (int i = 0; i < N_PROD; i++) begin
      if (ID_W'(i) == id) p = PRICES[i*CREDIT_W +: CREDIT_W];
    end
    return p;
  endfunction

  logic [CREDIT_W:0]   coin_sum;
  logic                coin_ok;
  logic [CREDIT_W-1:0] sel_price;
  logic                sel_ok;
  logic [CREDIT_W-1:0] pay_left;

  // Acceptance decisions for coin and selection, plus credit left after the current payout coin.
  always_comb begin
    coin_sum  = {1'b0, credit} + {1'b0, coin_val(coin)};
    coin_ok   = (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));
    sel_price = price_of(sel_id);
    sel_ok    = ({1'b0, sel_id} < (ID_W+1)'(N_PROD)) && (credit >= sel_price);
    pay_left  = credit - coin_val(chg_coin);
  end

  // Controller FSM with all outputs registered; pulses default low each cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      vend      <= 1'b0;
      vend_id   <= '0;
      chg_valid <= 1'b0;
      chg_coin  <= 2'b00;
      credit    <= '0;
      coin_rej  <= 1'b0;
      sel_nack  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      vend     <= 1'b0;
      coin_rej <= 1'b0;
      sel_nack <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cancel && (credit != '0)) begin
            // Refund takes the cycle; a coin arriving alongside cannot be credited.
            state     <= S_REFUND;
            busy      <= 1'b1;
            chg_valid <= 1'b1;
            chg_coin  <= greedy_coin(credit);
            coin_rej  <= (coin != 2'b00);
          end else if (coin != 2'b00) begin
            if (coin_ok) credit   <= coin_sum[CREDIT_W-1:0];
            else         coin_rej <= 1'b1;
          end else if (sel && !cancel) begin
            if (!sel_ok) begin
              sel_nack <= 1'b1;
            end else begin
              credit  <= credit - sel_price;
              vend    <= 1'b1;
              vend_id <= sel_id;
              state   <= S_VEND;
              busy    <= 1'b1;
            end
          end
        end
        S_VEND: begin
          coin_rej <= (coin != 2'b00);
`ifdef VEND_CREDIT_HOLD_EN
          state <= S_IDLE;
          busy  <= 1'b0;
`else
          if (credit != '0) begin
            state     <= S_CHANGE;
            chg_valid <= 1'b1;
            chg_coin  <= greedy_coin(credit);
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
`endif
        end
        S_CHANGE, S_REFUND: begin
          coin_rej <= (coin != 2'b00);
          if (chg_valid && chg_ready) begin
            credit <= pay_left;
            if (pay_left == '0) begin
              state     <= S_IDLE;
              busy      <= 1'b0;
              chg_valid <= 1'b0;
              chg_coin  <= 2'b00;
            end else begin
              chg_coin <= greedy_coin(pay_left);
            end
          end
        end
        default: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          chg_valid <= 1'b0;
          chg_coin  <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Directed testbench for vend_ctrl_multi with default parameters
// (prices: id0=30, id1=45, id2=60, id3=100; MAX_CREDIT=100).
module tb_vend_ctrl_multi;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] coin = 2'b00;
  logic       sel = 1'b0;
  logic [1:0] sel_id = 2'd0;
  logic       cancel = 1'b0;
  logic       chg_ready = 1'b0;
  logic       vend;
  logic [1:0] vend_id;
  logic       chg_valid;
  logic [1:0] chg_coin;
  logic [7:0] credit;
  logic       coin_rej;
  logic       sel_nack;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  vend_ctrl_multi dut (
    .clk(clk), .rst_n(rst_n), .coin(coin), .sel(sel), .sel_id(sel_id),
    .cancel(cancel), .chg_ready(chg_ready), .vend(vend), .vend_id(vend_id),
    .chg_valid(chg_valid), .chg_coin(chg_coin), .credit(credit),
    .coin_rej(coin_rej), .sel_nack(sel_nack), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put_coin(input logic [1:0] c);
    coin = c;
    step();
    coin = 2'b00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_tests++;
    if ({vend, vend_id, chg_valid, chg_coin, credit, coin_rej, sel_nack, busy} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0",
               {vend, vend_id, chg_valid, chg_coin, credit, coin_rej, sel_nack, busy});
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_change();
    chg_ready = 1'b1;
    put_coin(2'b10);
    put_coin(2'b10);
    put_coin(2'b11);
    n_tests++;
    if (credit !== 8'd45) begin n_fail++; $display("FAIL credit_45: got %0d want 45", credit); end
    sel = 1'b1; sel_id = 2'd0;
    step();
    sel = 1'b0;
    n_tests++;
    if ({vend, vend_id, credit, busy} !== {1'b1, 2'd0, 8'd15, 1'b1}) begin
      n_fail++; $display("FAIL vend_id0: got vend=%0d id=%0d credit=%0d busy=%0d want 1 0 15 1", vend, vend_id, credit, busy);
    end
    step();
    n_tests++;
    if ({vend, chg_valid, chg_coin, credit} !== {1'b0, 1'b1, 2'b10, 8'd15}) begin
      n_fail++; $display("FAIL change_first: got vend=%0d v=%0d coin=%0d credit=%0d want 0 1 2 15", vend, chg_valid, chg_coin, credit);
    end
    step();
    n_tests++;
    if ({chg_valid, chg_coin, credit} !== {1'b1, 2'b01, 8'd5}) begin
      n_fail++; $display("FAIL change_second: got v=%0d coin=%0d credit=%0d want 1 1 5", chg_valid, chg_coin, credit);
    end
    step();
    n_tests++;
    if ({chg_valid, credit, busy} !== {1'b0, 8'd0, 1'b0}) begin
      n_fail++; $display("FAIL change_done: got v=%0d credit=%0d busy=%0d want 0 0 0", chg_valid, credit, busy);
    end
  endtask

  task automatic test_max_credit();
    chg_ready = 1'b0;
    put_coin(2'b11); put_coin(2'b11); put_coin(2'b11);
    put_coin(2'b10); put_coin(2'b10);
    n_tests++;
    if (credit !== 8'd95) begin n_fail++; $display("FAIL credit_95: got %0d want 95", credit); end
    put_coin(2'b11);
    n_tests++;
    if ({coin_rej, credit} !== {1'b1, 8'd95}) begin
      n_fail++; $display("FAIL over_max_rej: got rej=%0d credit=%0d want 1 95", coin_rej, credit);
    end
    put_coin(2'b01);
    n_tests++;
    if ({coin_rej, credit} !== {1'b0, 8'd100}) begin
      n_fail++; $display("FAIL credit_100: got rej=%0d credit=%0d want 0 100", coin_rej, credit);
    end
    sel = 1'b1; sel_id = 2'd3;
    step();
    sel = 1'b0;
    n_tests++;
    if ({vend, vend_id, credit} !== {1'b1, 2'd3, 8'd0}) begin
      n_fail++; $display("FAIL vend_id3: got vend=%0d id=%0d credit=%0d want 1 3 0", vend, vend_id, credit);
    end
    step();
    n_tests++;
    if ({vend, chg_valid, busy} !== 3'b000) begin
      n_fail++; $display("FAIL exact_no_change: got vend=%0d v=%0d busy=%0d want 0 0 0", vend, chg_valid, busy);
    end
    step();
    n_tests++;
    if ({chg_valid, busy, credit} !== {1'b0, 1'b0, 8'd0}) begin
      n_fail++; $display("FAIL exact_idle: got v=%0d busy=%0d credit=%0d want 0 0 0", chg_valid, busy, credit);
    end
  endtask

  task automatic test_nack_refund();
    logic [1:0] got [0:7];
    int n;
    put_coin(2'b11); put_coin(2'b10); put_coin(2'b01);
    sel = 1'b1; sel_id = 2'd2;
    step();
    sel = 1'b0;
    n_tests++;
    if ({sel_nack, vend, busy, credit} !== {1'b1, 1'b0, 1'b0, 8'd40}) begin
      n_fail++; $display("FAIL nack_price: got nack=%0d vend=%0d busy=%0d credit=%0d want 1 0 0 40", sel_nack, vend, busy, credit);
    end
    step();
    n_tests++;
    if (sel_nack !== 1'b0) begin n_fail++; $display("FAIL nack_pulse: got %0d want 0", sel_nack); end
    chg_ready = 1'b1;
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (!busy) break;
      if (chg_valid && n < 8) begin got[n] = chg_coin; n++; end
      step();
    end
    n_tests++;
    if (n !== 3) begin n_fail++; $display("FAIL refund_count: got %0d want 3", n); end
    else begin
      n_tests++;
      if ({got[0], got[1], got[2]} !== {2'b11, 2'b10, 2'b01}) begin
        n_fail++; $display("FAIL refund_coins: got %0d %0d %0d want 3 2 1", got[0], got[1], got[2]);
      end
    end
    n_tests++;
    if ({busy, chg_valid, credit} !== {1'b0, 1'b0, 8'd0}) begin
      n_fail++; $display("FAIL refund_done: got busy=%0d v=%0d credit=%0d want 0 0 0", busy, chg_valid, credit);
    end
  endtask

  task automatic test_stall();
    chg_ready = 1'b0;
    put_coin(2'b11); put_coin(2'b11); put_coin(2'b11);
    sel = 1'b1; sel_id = 2'd1;
    step();
    sel = 1'b0;
    n_tests++;
    if ({vend, vend_id, credit} !== {1'b1, 2'd1, 8'd30}) begin
      n_fail++; $display("FAIL vend_id1: got vend=%0d id=%0d credit=%0d want 1 1 30", vend, vend_id, credit);
    end
    step();
    for (int i = 0; i < 3; i++) begin
      if (i == 0) coin = 2'b01;
      step();
      coin = 2'b00;
      n_tests++;
      if ({chg_valid, chg_coin, credit} !== {1'b1, 2'b11, 8'd30}) begin
        n_fail++; $display("FAIL stall_hold%0d: got v=%0d coin=%0d credit=%0d want 1 3 30", i, chg_valid, chg_coin, credit);
      end
      if (i == 0) begin
        n_tests++;
        if (coin_rej !== 1'b1) begin n_fail++; $display("FAIL busy_coin_rej: got %0d want 1", coin_rej); end
      end
    end
    chg_ready = 1'b1;
    step();
    n_tests++;
    if ({chg_valid, chg_coin, credit} !== {1'b1, 2'b01, 8'd5}) begin
      n_fail++; $display("FAIL stall_release: got v=%0d coin=%0d credit=%0d want 1 1 5", chg_valid, chg_coin, credit);
    end
    step();
    n_tests++;
    if ({chg_valid, busy, credit} !== {1'b0, 1'b0, 8'd0}) begin
      n_fail++; $display("FAIL stall_done: got v=%0d busy=%0d credit=%0d want 0 0 0", chg_valid, busy, credit);
    end
  endtask

  task automatic test_cancel_sel_reset();
    chg_ready = 1'b1;
    put_coin(2'b11); put_coin(2'b11);
    cancel = 1'b1; sel = 1'b1; sel_id = 2'd0;
    step();
    cancel = 1'b0; sel = 1'b0;
    n_tests++;
    if ({vend, busy, chg_valid, chg_coin, credit} !== {1'b0, 1'b1, 1'b1, 2'b11, 8'd50}) begin
      n_fail++; $display("FAIL cancel_beats_sel: got vend=%0d busy=%0d v=%0d coin=%0d credit=%0d want 0 1 1 3 50",
                         vend, busy, chg_valid, chg_coin, credit);
    end
    step();
    n_tests++;
    if ({chg_valid, chg_coin, credit} !== {1'b1, 2'b11, 8'd25}) begin
      n_fail++; $display("FAIL first_refund_coin: got v=%0d coin=%0d credit=%0d want 1 3 25", chg_valid, chg_coin, credit);
    end
    rst_n = 1'b0;
    step();
    n_tests++;
    if ({vend, vend_id, chg_valid, chg_coin, credit, coin_rej, sel_nack, busy} !== 17'd0) begin
      n_fail++; $display("FAIL reset_mid_payout: got %h want 0",
                         {vend, vend_id, chg_valid, chg_coin, credit, coin_rej, sel_nack, busy});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if ({chg_valid, busy, credit} !== {1'b0, 1'b0, 8'd0}) begin
        n_fail++; $display("FAIL post_reset_quiet%0d: got v=%0d busy=%0d credit=%0d want 0 0 0", i, chg_valid, busy, credit);
      end
    end
  endtask

  task automatic test_credit_hold();
    int seen_valid;
    chg_ready = 1'b1;
    put_coin(2'b11); put_coin(2'b11); put_coin(2'b11);
    sel = 1'b1; sel_id = 2'd1;
    step();
    sel = 1'b0;
    n_tests++;
    if ({vend, vend_id, credit} !== {1'b1, 2'd1, 8'd30}) begin
      n_fail++; $display("FAIL hold_vend: got vend=%0d id=%0d credit=%0d want 1 1 30", vend, vend_id, credit);
    end
    seen_valid = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (chg_valid) seen_valid++;
    end
    n_tests++;
    if ({busy, credit} !== {1'b0, 8'd30} || seen_valid != 0) begin
      n_fail++; $display("FAIL hold_idle: got busy=%0d credit=%0d valid_cycles=%0d want 0 30 0", busy, credit, seen_valid);
    end
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    n_tests++;
    if ({chg_valid, chg_coin} !== {1'b1, 2'b11}) begin
      n_fail++; $display("FAIL hold_refund: got v=%0d coin=%0d want 1 3", chg_valid, chg_coin);
    end
    step();
    step();
    n_tests++;
    if ({busy, credit} !== {1'b0, 8'd0}) begin
      n_fail++; $display("FAIL hold_refund_done: got busy=%0d credit=%0d want 0 0", busy, credit);
    end
  endtask

  initial begin
    test_reset();
`ifdef VEND_CREDIT_HOLD_EN
    test_credit_hold();
    test_max_credit();
    test_nack_refund();
`else
    test_change();
    test_max_credit();
    test_nack_refund();
    test_stall();
    test_cancel_sel_reset();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
